change_dispenser: RTL and testbench

- Return-path counterpart of the vending controller's coin-acceptance path. The controller's `money` input takes one-hot denominations in; this block pays change out as one-hot coin pulses to the coin hopper.
- The controller issues a change amount on entry to RETURN_CHANGE. This block pays it out greedily (20, then 10, then 5) with a per-coin valid/ack handshake.
- It keeps per-denomination inventory counters and reports completion or shortfall.

---
 rtl/change_dispenser.sv | 161 ++++++++++++++++
 tb/tb_change_dispenser.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: pays a change amount greedily (20, 10, 5) as one-hot coin pulses with valid/ack.
// Optional macro CHANGE_DISPENSER_ACK_TIMEOUT_EN aborts a coin that is not acknowledged in time.
module change_dispenser #(
    parameter int MAX_MONEY   = 40,
    parameter int CNT_W       = 6,
    parameter int INIT_COUNT  = 10,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       change_amt,
    input  logic             refill,
    output logic [2:0]       coin_out,
    input  logic             coin_ack,
    output logic             done,
    output logic             error,
    output logic [7:0]       remaining,
    output logic [CNT_W-1:0] inv_5,
    output logic [CNT_W-1:0] inv_10,
    output logic [CNT_W-1:0] inv_20
);

    localparam int               CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] FILL    = CNT_W'((INIT_COUNT > CNT_MAX) ? CNT_MAX : INIT_COUNT);
    localparam logic [7:0]       MAX_AMT = 8'(MAX_MONEY);
    localparam logic [2:0]       COIN_5  = 3'b001;
    localparam logic [2:0]       COIN_10 = 3'b010;
    localparam logic [2:0]       COIN_20 = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PICK,
        WAIT_ACK,
        DONE,
        ERR
    } state_t;

    state_t           state, state_next;
    logic [2:0]       coin_next;
    logic [7:0]       remaining_next;
    logic [CNT_W-1:0] inv_5_next, inv_10_next, inv_20_next;
    logic             ack_timeout;

`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] ack_cnt;

    // Counts unacknowledged cycles of the current coin; zero whenever a coin is not pending.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT_ACK) begin
            ack_cnt <= '0;
        end else if (!coin_ack) begin
            ack_cnt <= ack_cnt + TO_W'(1);
        end
    end

    assign ack_timeout = (ack_cnt == TO_W'(ACK_TIMEOUT - 1));
`else
    // Timeout disabled; ACK_TIMEOUT stays in the parameter list so both builds share one interface.
    assign ack_timeout = 1'b0 && (ACK_TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            coin_out  <= 3'b000;
            remaining <= 8'd0;
            inv_5     <= FILL;
            inv_10    <= FILL;
            inv_20    <= FILL;
        end else begin
            state     <= state_next;
            coin_out  <= coin_next;
            remaining <= remaining_next;
            inv_5     <= inv_5_next;
            inv_10    <= inv_10_next;
            inv_20    <= inv_20_next;
        end
    end

    always_comb begin
        state_next     = state;
        coin_next      = coin_out;
        remaining_next = remaining;
        inv_5_next     = inv_5;
        inv_10_next    = inv_10;
        inv_20_next    = inv_20;

        case (state)
            IDLE: begin
                if (refill) begin
                    inv_5_next  = FILL;
                    inv_10_next = FILL;
                    inv_20_next = FILL;
                end
                if (req_valid) begin
                    remaining_next = change_amt;
                    state_next     = CHECK;
                end
            end
            CHECK: begin
                if ((remaining % 8'd5) != 8'd0 || remaining > MAX_AMT) begin
                    state_next = ERR;
                end else begin
                    state_next = PICK;
                end
            end
            // Largest denomination that fits the balance and is still in stock.
            PICK: begin
                if (remaining == 8'd0) begin
                    state_next = DONE;
                end else if (remaining >= 8'd20 && inv_20 != '0) begin
                    coin_next  = COIN_20;
                    state_next = WAIT_ACK;
                end else if (remaining >= 8'd10 && inv_10 != '0) begin
                    coin_next  = COIN_10;
                    state_next = WAIT_ACK;
                end else if (remaining >= 8'd5 && inv_5 != '0) begin
                    coin_next  = COIN_5;
                    state_next = WAIT_ACK;
                end else begin
                    state_next = ERR;
                end
            end
            WAIT_ACK: begin
                if (coin_ack) begin
                    case (coin_out)
                        COIN_20: begin
                            remaining_next = remaining - 8'd20;
                            inv_20_next    = inv_20 - CNT_W'(1);
                        end
                        COIN_10: begin
                            remaining_next = remaining - 8'd10;
                            inv_10_next    = inv_10 - CNT_W'(1);
                        end
                        default: begin
                            remaining_next = remaining - 8'd5;
                            inv_5_next     = inv_5 - CNT_W'(1);
                        end
                    endcase
                    coin_next  = 3'b000;
                    state_next = PICK;
                end else if (ack_timeout) begin
                    coin_next  = 3'b000;
                    state_next = ERR;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign done      = (state == DONE);
    assign error     = (state == ERR);

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: vector table, hand-written corner sequences and randomized
// requests checked against an arithmetic greedy-payout model.
module tb_change_dispenser;

    localparam int INIT = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] change_amt;
    logic       refill;
    logic [2:0] coin_out;
    logic       coin_ack;
    logic       done;
    logic       error;
    logic [7:0] remaining;
    logic [5:0] inv_5, inv_10, inv_20;

    change_dispenser #(
        .MAX_MONEY(40),
        .CNT_W(6),
        .INIT_COUNT(INIT),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .change_amt(change_amt),
        .refill(refill),
        .coin_out(coin_out),
        .coin_ack(coin_ack),
        .done(done),
        .error(error),
        .remaining(remaining),
        .inv_5(inv_5),
        .inv_10(inv_10),
        .inv_20(inv_20)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: inventory counts indexed 0=5, 1=10, 2=20
    int denom[3] = '{5, 10, 20};
    int m_inv[3];
    int m_coins[$];
    int m_done, m_err, m_rem;

    function automatic bit is_legal(input int amt);
        return (amt % 5 == 0) && (amt <= 40);
    endfunction

    function automatic void model_request(input int amt, input bit do_refill);
        int picked;
        if (do_refill) m_inv = '{INIT, INIT, INIT};
        m_coins.delete();
        m_rem  = amt;
        m_done = 0;
        m_err  = 0;
        if (!is_legal(amt)) begin
            m_err = 1;
            return;
        end
        while (m_rem > 0) begin
            picked = -1;
            for (int i = 2; i >= 0; i--)
                if (picked < 0 && denom[i] <= m_rem && m_inv[i] > 0) picked = i;
            if (picked < 0) begin
                m_err = 1;
                return;
            end
            m_coins.push_back(picked);
            m_inv[picked]--;
            m_rem -= denom[picked];
        end
        m_done = 1;
    endfunction

    logic [2:0] got_coins[$];
    int got_done, got_err, first_coin_cyc, end_cyc, unstable;

    // Issues one request and plays the hopper; ack_delay < 0 never acknowledges.
    task automatic apply_stimulus(input int amt, input int ack_delay, input bit do_refill, input bit noise);
        int         held;
        bit         in_coin;
        bit         finished;
        logic [2:0] cur;
        got_coins.delete();
        got_done = 0; got_err = 0; first_coin_cyc = -1; end_cyc = -1; unstable = 0;
        held = 0; in_coin = 0; finished = 0; cur = 3'b000;
        @(negedge clk);
        check_output("req_ready before request", int'(req_ready), 1);
        req_valid  = 1'b1;
        change_amt = 8'(amt);
        refill     = do_refill;
        @(negedge clk);
        req_valid  = 1'b0;
        refill     = 1'b0;
        change_amt = 8'($urandom);
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            @(negedge clk);
            coin_ack = 1'b0;
            refill   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (coin_out != 3'b000) begin
                if (!in_coin) begin
                    got_coins.push_back(coin_out);
                    cur     = coin_out;
                    in_coin = 1;
                    held    = 1;
                    if (first_coin_cyc < 0) first_coin_cyc = cyc;
                end else begin
                    if (coin_out != cur) unstable++;
                    held++;
                end
                if (ack_delay >= 0 && held > ack_delay) coin_ack = 1'b1;
            end else begin
                in_coin  = 0;
                coin_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (done) got_done++;
            if (error) got_err++;
            if (done || error) begin
                end_cyc   = cyc;
                finished  = 1;
                coin_ack  = 1'b0;
                refill    = 1'b0;
                req_valid = 1'b0;
            end
        end
        coin_ack  = 1'b0;
        refill    = 1'b0;
        req_valid = 1'b0;
        if (!finished) check_output("request completion within budget", 0, 1);
    endtask

    task automatic run_and_model(input int amt, input int d, input bit rf, input bit noise, input string tag);
        int exp_end;
        model_request(amt, rf);
        apply_stimulus(amt, d, rf, noise);
        exp_end = is_legal(amt) ? 2 + m_coins.size() * (d + 2) : 1;
        check_output({tag, " done"}, got_done, m_done);
        check_output({tag, " error"}, got_err, m_err);
        check_output({tag, " coin count"}, got_coins.size(), m_coins.size());
        for (int k = 0; k < m_coins.size() && k < got_coins.size(); k++)
            check_output($sformatf("%s coin%0d", tag, k), int'(got_coins[k]), 1 << m_coins[k]);
        check_output({tag, " remaining"}, int'(remaining), m_rem);
        check_output({tag, " inv_5"}, int'(inv_5), m_inv[0]);
        check_output({tag, " inv_10"}, int'(inv_10), m_inv[1]);
        check_output({tag, " inv_20"}, int'(inv_20), m_inv[2]);
        check_output({tag, " coin stability"}, unstable, 0);
        check_output({tag, " latency"}, end_cyc, exp_end);
    endtask

    typedef struct {
        int         amt;
        int         ack_delay;
        int         exp_done;
        int         exp_err;
        int         exp_n;
        logic [11:0] exp_seq;
        int         exp_rem;
        int         exp_end;
        int         e5, e10, e20;
    } vec_t;

    vec_t vecs[10];

    initial begin
        reset = 1'b1; req_valid = 1'b0; change_amt = 8'd0; refill = 1'b0; coin_ack = 1'b0;

        // Every vector refills alongside the accept, so inventories start at 10/10/10
        vecs[0] = '{35,  1, 1, 0, 3, 12'b000_001_010_100, 0,   11, 9,  9,  9};
        vecs[1] = '{40,  0, 1, 0, 2, 12'b000_000_100_100, 0,   6,  10, 10, 8};
        vecs[2] = '{0,   2, 1, 0, 0, 12'b0,               0,   2,  10, 10, 10};
        vecs[3] = '{12,  1, 0, 1, 0, 12'b0,               12,  1,  10, 10, 10};
        vecs[4] = '{45,  1, 0, 1, 0, 12'b0,               45,  1,  10, 10, 10};
        vecs[5] = '{5,   0, 1, 0, 1, 12'b000_000_000_001, 0,   4,  9,  10, 10};
        vecs[6] = '{25,  3, 1, 0, 2, 12'b000_000_001_100, 0,   12, 9,  10, 9};
        vecs[7] = '{30,  2, 1, 0, 2, 12'b000_000_010_100, 0,   10, 10, 9,  9};
        vecs[8] = '{41,  0, 0, 1, 0, 12'b0,               41,  1,  10, 10, 10};
        vecs[9] = '{200, 0, 0, 1, 0, 12'b0,               200, 1,  10, 10, 10};

        repeat (2) @(negedge clk);
        check_output("reset req_ready", int'(req_ready), 1);
        check_output("reset coin_out", int'(coin_out), 0);
        check_output("reset done", int'(done), 0);
        check_output("reset error", int'(error), 0);
        check_output("reset remaining", int'(remaining), 0);
        check_output("reset inv_5", int'(inv_5), INIT);
        check_output("reset inv_10", int'(inv_10), INIT);
        check_output("reset inv_20", int'(inv_20), INIT);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            logic [11:0] seq;
            seq = vecs[i].exp_seq;
            apply_stimulus(vecs[i].amt, vecs[i].ack_delay, 1'b1, 1'b0);
            check_output($sformatf("vec%0d done", i), got_done, vecs[i].exp_done);
            check_output($sformatf("vec%0d error", i), got_err, vecs[i].exp_err);
            check_output($sformatf("vec%0d coin count", i), got_coins.size(), vecs[i].exp_n);
            for (int k = 0; k < vecs[i].exp_n && k < got_coins.size(); k++)
                check_output($sformatf("vec%0d coin%0d", i, k), int'(got_coins[k]), int'(seq[3*k +: 3]));
            check_output($sformatf("vec%0d remaining", i), int'(remaining), vecs[i].exp_rem);
            check_output($sformatf("vec%0d latency", i), end_cyc, vecs[i].exp_end);
            check_output($sformatf("vec%0d inv_5", i), int'(inv_5), vecs[i].e5);
            check_output($sformatf("vec%0d inv_10", i), int'(inv_10), vecs[i].e10);
            check_output($sformatf("vec%0d inv_20", i), int'(inv_20), vecs[i].e20);
        end

        // Drain the twenties, then 40 must fall back to four tens
        run_and_model(40, 0, 1'b1, 1'b0, "drain20");
        for (int i = 0; i < 4; i++) run_and_model(40, 0, 1'b0, 1'b0, "drain20");
        run_and_model(40, 1, 1'b0, 1'b0, "fallback");
        check_output("fallback inv_10", int'(inv_10), 6);
        check_output("fallback inv_20", int'(inv_20), 0);

        // Leave a single five in stock, then 15 can only be paid partially
        run_and_model(30, 0, 1'b0, 1'b0, "drain10");
        run_and_model(30, 0, 1'b0, 1'b0, "drain10");
        run_and_model(40, 0, 1'b0, 1'b0, "drain5");
        run_and_model(5, 0, 1'b0, 1'b0, "drain5");
        check_output("pre-shortfall inv_5", int'(inv_5), 1);
        run_and_model(15, 1, 1'b0, 1'b0, "shortfall");
        check_output("shortfall remaining", int'(remaining), 10);
        check_output("shortfall error", got_err, 1);
        check_output("shortfall done", got_done, 0);
        check_output("shortfall inv_5", int'(inv_5), 0);

        // Hold the ack off, then reset in the middle of the handshake
        run_and_model(0, 0, 1'b1, 1'b0, "refill zero");
        @(negedge clk);
        req_valid = 1'b1; change_amt = 8'd20;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("first coin at third edge", int'(coin_out), 3'b100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output($sformatf("held coin cycle%0d", i), int'(coin_out), 3'b100);
            check_output($sformatf("held coin no pulse%0d", i), int'(done | error), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_output("mid reset coin_out", int'(coin_out), 0);
        check_output("mid reset remaining", int'(remaining), 0);
        check_output("mid reset inv_20", int'(inv_20), INIT);
        check_output("mid reset req_ready", int'(req_ready), 1);
        check_output("mid reset done/error", int'(done | error), 0);
        reset = 1'b0;
        m_inv = '{INIT, INIT, INIT};
        @(negedge clk);
        check_output("after reset done/error", int'(done | error), 0);

        for (int t = 0; t < 60; t++) begin
            int amt;
            if ($urandom_range(0, 3) == 0) amt = int'($urandom_range(0, 60));
            else amt = 5 * int'($urandom_range(0, 8));
            run_and_model(amt, int'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0), 1'b1,
                          $sformatf("rand%0d amt%0d", t, amt));
        end

`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
        begin
            int held20;
            int err_seen;
            int inv20_before;
            held20 = 0; err_seen = 0;
            inv20_before = int'(inv_20);
            @(negedge clk);
            req_valid = 1'b1; change_amt = 8'd20;
            @(negedge clk);
            req_valid = 1'b0;
            for (int c = 0; c < 60 && err_seen == 0; c++) begin
                @(negedge clk);
                if (coin_out == 3'b100) held20++;
                if (error) begin
                    err_seen = 1;
                    check_output("timeout coin dropped", int'(coin_out), 0);
                    check_output("timeout remaining", int'(remaining), 20);
                    check_output("timeout inv_20", int'(inv_20), inv20_before);
                end
            end
            check_output("timeout error pulse", err_seen, 1);
            check_output("timeout coin cycles", held20, 16);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
